demux_decoder3: RTL and testbench
=================================

Name: demux_decoder3

Overview:
- Receive-side counterpart of the 3-way transmit symbol mux. It takes one 2-bit line symbol per accepted beat and matches it against the three legal transmit codes. The match recovers the 2-bit select pair {sB, sA} that drove the transmit mux.
- Two recovered pairs, high pair first, are packed into a 4-bit Rx_Data word, which is offered downstream on a valid/ready handshake.
- Illegal symbols and framing slips are flagged and counted.
- Sits between the line-side symbol sampler and the receive data path.

Parameters:
- CODE0, 2'b00, line symbol sent for select 2'b00 (in0 slot)
- CODE1, 2'b01, line symbol sent for select 2'b01 (in1 slot)
- CODE2, 2'b10, line symbol sent for select 2'b10 (in2 slot)
- ERR_W, 8, width of the saturating error counter

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  synchronous active-low reset
- sym  input  2  received line symbol
- sym_valid  input  1  sym is valid this cycle
- sym_sof  input  1  qualifies sym as the first (high-pair) symbol of a word
- sym_ready  output  1  decoder can accept sym this cycle
- Rx_Data  output  4  decoded word; [3:2] from the first symbol, [1:0] from the second
- rx_valid  output  1  Rx_Data valid
- rx_ready  input  1  downstream accepts Rx_Data
- rx_err  output  1  word contains at least one illegal symbol; qualified by rx_valid
- frame_err  output  1  one-cycle pulse when a partial word is discarded
- err_cnt  output  ERR_W  saturating count of illegal symbols plus framing slips

Behaviour:
- Reset is synchronous and active-low on rst_n, sampled on the clk rising edge. While rst_n=0 (sampled):
  - state=HI;
  - Rx_Data=0, rx_valid=0, rx_err=0, frame_err=0, err_cnt=0;
  - partial register and its error bit cleared.
- Reset asserted mid-word or mid-handshake discards everything; nothing is emitted afterwards.
- A beat is accepted when sym_valid && sym_ready.
- Symbol decode (combinational):
  - sym==CODE0 -> pair 00; sym==CODE1 -> 01; sym==CODE2 -> 10.
  - If the codes are not distinct, the lowest index wins.
  - No match -> pair 00 and the beat is marked illegal. With default codes, sym=2'b11 is illegal.
- FSM, two states:
  - HI: an accepted beat writes its pair into partial[1:0] and its illegal flag into partial_err, then moves to LO. sym_sof is ignored in HI; a missing sof is not an error.
  - LO, accepted beat with sym_sof=0: Rx_Data <= {partial, pair}, rx_err <= partial_err | illegal, rx_valid <= 1, next state HI.
  - LO, accepted beat with sym_sof=1: the partial word is dropped, frame_err pulses for 1 cycle, err_cnt is incremented, and the beat is treated as a new high pair (stays effectively in HI->LO: partial reloaded, state remains LO).
- sym_ready = (state==HI) || !rx_valid || rx_ready.
  - The high pair is always accepted.
  - The low pair stalls only while the output slot is full and not draining.
- Output slot:
  - rx_valid clears on rx_valid && rx_ready unless a new word completes in the same cycle, in which case it stays 1 with the new data. This gives full throughput.
  - Rx_Data and rx_err hold stable while rx_valid && !rx_ready.
- Latency: rx_valid rises 1 cycle after the LO beat is accepted. Sustained rate is 1 word per 2 accepted beats.
- err_cnt:
  - +1 per accepted illegal beat, +1 per frame slip.
  - If both occur on the same beat, the increment is +2.
  - Saturates at all-ones and never wraps.
- sym is a don't-care when sym_valid=0. sym_valid without sym_ready is not consumed.

Decomposition:
- Shared package, demux_pkg:
  - state encoding localparams ST_HI, ST_LO;
  - default code constants CODE0_DEF, CODE1_DEF, CODE2_DEF, also used by the encoder-side bench;
  - the 2-bit pair type.
- One natural sub-module: sym_match3. It is combinational, takes sym and the three codes, and returns pair and illegal. It is reused by the bench's reference model.
- The FSM, output slot and counter stay in the top module.

Test Plan:
- Basic decode, rx_ready=1, sof on the first beat: beats 2'b10 (sof), 2'b01 -> Rx_Data=4'b1001, rx_valid=1 one cycle after the second beat, rx_err=0, err_cnt=0.
- Illegal symbol: beats 2'b11 (sof), 2'b00 -> Rx_Data=4'b0000, rx_err=1, err_cnt=1. Feed 300 illegal beats -> err_cnt saturates at 255.
- Backpressure: rx_ready=0, complete word 4'b0110, then a further high beat 2'b10 (accepted, sym_ready=1) and low beat 2'b10 (sym_ready=0, stalled). Raise rx_ready -> 4'b0110 is taken, the next cycle shows 4'b1010, and Rx_Data is unchanged during the stall.
- Framing slip: beat 2'b01 (sof), then 2'b10 with sof=1, then 2'b00 -> frame_err pulses once, err_cnt=1, output word 4'b1000.
- Reset mid-word: one high beat accepted, then rst_n=0 for 1 cycle, then beats 2'b00 (sof), 2'b01 -> Rx_Data=4'b0001 with no stale pair and err_cnt=0.
- Custom codes CODE0=2'b11, CODE1=2'b10, CODE2=2'b01: beats 2'b11, 2'b01 -> Rx_Data=4'b0010. Beat 2'b00 flagged illegal.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the 3-way symbol demux/decoder and its encoder-side peers.
package demux_pkg;

    // Recovered select pair {sB, sA}
    typedef logic [1:0] pair_t;

    // Word-assembly FSM: waiting for the high pair, or holding it and waiting for the low pair
    typedef enum logic {
        ST_HI = 1'b0,
        ST_LO = 1'b1
    } state_t;

    // Default line codes for the in0/in1/in2 slots
    localparam pair_t CODE0_DEF = 2'b00;
    localparam pair_t CODE1_DEF = 2'b01;
    localparam pair_t CODE2_DEF = 2'b10;

endpackage

// File: rtl/sym_match3.sv
// Combinational match of one line symbol against the three transmit codes.
module sym_match3
    import demux_pkg::*;
(
    input  pair_t sym,
    input  pair_t code0,
    input  pair_t code1,
    input  pair_t code2,
    output pair_t pair,
    output logic  illegal
);

    // Priority match: when codes collide the lowest slot index wins; no match is illegal
    always_comb begin
        pair    = 2'b00;
        illegal = 1'b0;
        if (sym == code0) begin
            pair = 2'b00;
        end else if (sym == code1) begin
            pair = 2'b01;
        end else if (sym == code2) begin
            pair = 2'b10;
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/demux_decoder3.sv
// Receive-side decoder: two line symbols -> one 4-bit word on a valid/ready output slot.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are both 1.
// Input side (sym_valid/sym_ready) and output side (rx_valid/rx_ready) follow this rule;
// the producer must hold its data stable while valid is high and ready is low.
module demux_decoder3
    import demux_pkg::*;
#(
    parameter pair_t CODE0 = CODE0_DEF,
    parameter pair_t CODE1 = CODE1_DEF,
    parameter pair_t CODE2 = CODE2_DEF,
    parameter int    ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       sym,
    input  logic             sym_valid,
    input  logic             sym_sof,
    output logic             sym_ready,
    output logic [3:0]       Rx_Data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_err,
    output logic             frame_err,
    output logic [ERR_W-1:0] err_cnt
);

    state_t state, state_next;
    pair_t  partial;
    logic   partial_err;

    pair_t  pair;
    logic   illegal;
    logic   accept;
    logic   load_hi;
    logic   complete;
    logic   slip;
    logic [1:0]     err_inc;
    logic [ERR_W:0] err_sum;

    sym_match3 u_match (
        .sym     (sym),
        .code0   (CODE0),
        .code1   (CODE1),
        .code2   (CODE2),
        .pair    (pair),
        .illegal (illegal)
    );

    // The high pair is always taken; the low pair waits only while the output slot is full and stuck
    assign sym_ready = (state == ST_HI) || !rx_valid || rx_ready;
    assign accept    = sym_valid && sym_ready;

    // Next-state and per-beat actions: load a high pair, complete a word, or restart on a slip
    always_comb begin
        state_next = state;
        load_hi    = 1'b0;
        complete   = 1'b0;
        slip       = 1'b0;
        if (accept) begin
            case (state)
                ST_HI: begin
                    load_hi    = 1'b1;
                    state_next = ST_LO;
                end
                ST_LO: begin
                    if (sym_sof) begin
                        load_hi = 1'b1;
                        slip    = 1'b1;
                    end else begin
                        complete   = 1'b1;
                        state_next = ST_HI;
                    end
                end
                default: state_next = ST_HI;
            endcase
        end
    end

    // Error increment for this beat (illegal symbol and slip can coincide) and its saturating sum
    always_comb begin
        err_inc = {1'b0, accept && illegal} + {1'b0, slip};
        err_sum = {1'b0, err_cnt} + (ERR_W + 1)'(err_inc);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_HI;
        end else begin
            state <= state_next;
        end
    end

    // Partial-word register holding the high pair and whether it was illegal
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            partial     <= 2'b00;
            partial_err <= 1'b0;
        end else if (load_hi) begin
            partial     <= pair;
            partial_err <= illegal;
        end
    end

    // Output slot: a completing word overwrites/refills it, otherwise it empties on a transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Rx_Data  <= 4'b0000;
            rx_err   <= 1'b0;
            rx_valid <= 1'b0;
        end else if (complete) begin
            Rx_Data  <= {partial, pair};
            rx_err   <= partial_err | illegal;
            rx_valid <= 1'b1;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

    // Slip pulse and saturating error counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            frame_err <= slip;
            if (err_sum[ERR_W]) begin
                err_cnt <= '1;
            end else begin
                err_cnt <= err_sum[ERR_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_demux_decoder3.sv
// Bench for demux_decoder3: default-code and custom-code instances share one beat stream.
module tb_demux_decoder3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sym = 2'b00;
    logic       sym_valid = 1'b0;
    logic       sym_sof = 1'b0;
    logic       rx_ready = 1'b1;

    logic       sym_ready_a, rx_valid_a, rx_err_a, frame_err_a;
    logic [3:0] rx_data_a;
    logic [7:0] err_cnt_a;
    logic       sym_ready_c, rx_valid_c, rx_err_c, frame_err_c;
    logic [3:0] rx_data_c;
    logic [7:0] err_cnt_c;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [1:0] codes_a [3] = '{2'b00, 2'b01, 2'b10};
    logic [1:0] codes_c [3] = '{2'b11, 2'b10, 2'b01};
    logic [4:0] exp_a[$];
    logic [4:0] exp_c[$];
    bit         m_have_hi = 0;
    logic [1:0] m_sym_hi = 2'b00;
    int         m_cnt_a = 0;
    int         m_cnt_c = 0;
    int         m_slips = 0;
    int         seen_fe_a = 0;
    int         seen_fe_c = 0;

    demux_decoder3 dut_a (
        .clk(clk), .rst_n(rst_n), .sym(sym), .sym_valid(sym_valid), .sym_sof(sym_sof),
        .sym_ready(sym_ready_a), .Rx_Data(rx_data_a), .rx_valid(rx_valid_a),
        .rx_ready(rx_ready), .rx_err(rx_err_a), .frame_err(frame_err_a), .err_cnt(err_cnt_a)
    );

    demux_decoder3 #(.CODE0(2'b11), .CODE1(2'b10), .CODE2(2'b01), .ERR_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .sym(sym), .sym_valid(sym_valid), .sym_sof(sym_sof),
        .sym_ready(sym_ready_c), .Rx_Data(rx_data_c), .rx_valid(rx_valid_c),
        .rx_ready(rx_ready), .rx_err(rx_err_c), .frame_err(frame_err_c), .err_cnt(err_cnt_c)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Slot index of the first code equal to s; -1 when no code matches
    function automatic int slot_of(input bit cust, input logic [1:0] s);
        for (int i = 0; i < 3; i++) begin
            if ((cust ? codes_c[i] : codes_a[i]) == s) return i;
        end
        return -1;
    endfunction

    function automatic logic [4:0] word_of(input bit cust, input logic [1:0] hi, input logic [1:0] lo);
        int sh = slot_of(cust, hi);
        int sl = slot_of(cust, lo);
        int v  = (sh < 0 ? 0 : sh) * 4 + (sl < 0 ? 0 : sl);
        bit e  = (sh < 0) || (sl < 0);
        return {e, 4'(v)};
    endfunction

    function automatic int sat_add(input int c, input int n);
        return (c + n > 255) ? 255 : c + n;
    endfunction

    // Model of one accepted beat
    task automatic model_beat(input logic [1:0] s, input bit sof);
        if (m_have_hi && !sof) begin
            exp_a.push_back(word_of(0, m_sym_hi, s));
            exp_c.push_back(word_of(1, m_sym_hi, s));
            m_have_hi = 0;
        end else begin
            if (m_have_hi) begin
                m_slips++;
                m_cnt_a = sat_add(m_cnt_a, 1);
                m_cnt_c = sat_add(m_cnt_c, 1);
            end
            m_have_hi = 1;
            m_sym_hi  = s;
        end
        if (slot_of(0, s) < 0) m_cnt_a = sat_add(m_cnt_a, 1);
        if (slot_of(1, s) < 0) m_cnt_c = sat_add(m_cnt_c, 1);
    endtask

    // Driver: present one beat, wait for acceptance; release backpressure after a short stall
    task automatic beat(input logic [1:0] s, input bit sof);
        int n = 0;
        sym = s; sym_sof = sof; sym_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (sym_ready_a) break;
            n++;
            if (n == 3) begin
                @(posedge clk); #1 rx_ready = 1'b1;
            end
            if (n > 50) begin
                chk("beat_accept_timeout", 0, 1);
                break;
            end
        end
        chk("sym_ready_match", int'(sym_ready_c), int'(sym_ready_a));
        model_beat(s, sof);
        @(posedge clk); #1;
        sym_valid = 1'b0;
        sym_sof = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rx_ready = 1'b1;
        while ((exp_a.size() != 0 || exp_c.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("drain_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_a.delete(); exp_c.delete();
        m_have_hi = 0; m_cnt_a = 0; m_cnt_c = 0;
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_err_cnt_a"}, int'(err_cnt_a), m_cnt_a);
        chk({tag, "_err_cnt_c"}, int'(err_cnt_c), m_cnt_c);
        chk({tag, "_frame_err_a"}, seen_fe_a, m_slips);
        chk({tag, "_frame_err_c"}, seen_fe_c, m_slips);
    endtask

    // Monitor / scoreboard: pop on each output transfer, check stability while stalled
    logic       stall_a = 1'b0;
    logic [4:0] held_a = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_a <= 1'b0;
        end else begin
            if (frame_err_a) seen_fe_a++;
            if (frame_err_c) seen_fe_c++;
            if (stall_a && rx_valid_a) chk("stall_hold_a", int'({rx_err_a, rx_data_a}), int'(held_a));
            if (rx_valid_a && rx_ready) begin
                if (exp_a.size() == 0) chk("unexpected_word_a", 1, 0);
                else chk("word_a", int'({rx_err_a, rx_data_a}), int'(exp_a.pop_front()));
            end
            if (rx_valid_c && rx_ready) begin
                if (exp_c.size() == 0) chk("unexpected_word_c", 1, 0);
                else chk("word_c", int'({rx_err_c, rx_data_c}), int'(exp_c.pop_front()));
            end
            stall_a <= rx_valid_a && !rx_ready;
            held_a  <= {rx_err_a, rx_data_a};
        end
    end

    // Stimulus
    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Reset state
        chk("rst_rx_valid", int'(rx_valid_a), 0);
        chk("rst_rx_data", int'(rx_data_a), 0);
        chk("rst_rx_err", int'(rx_err_a), 0);
        chk("rst_frame_err", int'(frame_err_a), 0);
        chk("rst_err_cnt", int'(err_cnt_a), 0);
        chk("rst_sym_ready", int'(sym_ready_a), 1);

        // Basic decode with one-cycle latency
        rx_ready = 1'b1;
        beat(2'b10, 1);
        beat(2'b01, 0);
        chk("basic_valid_latency", int'(rx_valid_a), 1);
        chk("basic_data", int'(rx_data_a), 4'b1001);
        drain();
        check_counts("basic");

        // Illegal symbol
        beat(2'b11, 1);
        beat(2'b00, 0);
        drain();
        check_counts("illegal");

        // Backpressure: slot full, high beat still taken, low beat stalls
        rx_ready = 1'b0;
        beat(2'b01, 1);
        beat(2'b10, 0);
        beat(2'b10, 1);
        @(negedge clk);
        chk("bp_sym_ready_low", int'(sym_ready_a), 0);
        chk("bp_hold_data", int'(rx_data_a), 4'b0110);
        @(posedge clk); #1;
        beat(2'b10, 0);
        drain();
        check_counts("backpressure");

        // Framing slip
        beat(2'b01, 1);
        beat(2'b10, 1);
        beat(2'b00, 0);
        drain();
        check_counts("slip");

        // Reset mid-word
        beat(2'b10, 1);
        do_reset();
        beat(2'b00, 1);
        beat(2'b01, 0);
        chk("rstmid_data", int'(rx_data_a), 4'b0001);
        drain();
        check_counts("rstmid");

        // Custom codes: 11 -> in0, 01 -> in2; 00 illegal there
        beat(2'b11, 1);
        beat(2'b01, 0);
        chk("custom_data", int'(rx_data_c), 4'b0010);
        beat(2'b00, 1);
        beat(2'b00, 0);
        drain();
        check_counts("custom");

        // Randomized traffic with random backpressure and idle gaps
        for (int i = 0; i < 400; i++) begin
            logic [1:0] s;
            bit sof;
            s = 2'($urandom_range(0, 3));
            sof = m_have_hi ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 1);
            rx_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            beat(s, sof);
        end
        drain();
        check_counts("random");

        // Saturation: 300 illegal beats for the default codes
        do_reset();
        for (int i = 0; i < 300; i++) begin
            beat(2'b11, (i % 2) == 0);
        end
        drain();
        chk("sat_err_cnt_a", int'(err_cnt_a), 255);
        check_counts("sat");

        chk("queue_a_empty", exp_a.size(), 0);
        chk("queue_c_empty", exp_c.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
